baccarat_match_ctrl: RTL and testbench
======================================

BACCARAT_MATCH_CTRL -- requirements
Module: baccarat_match_ctrl

Interface
REQ-001 SHALL have parameter TALLY_W, default 4, width of each round-result counter.
REQ-002 SHALL have parameter TARGET_WINS, default 3, player or dealer win count that ends the match (1 .. 2^TALLY_W-1).
REQ-003 SHALL have parameter AUTO_NEXT, default 0, where 1 starts the next round automatically after HOLD_STEPS stepped cycles in S_DONE, and 0 waits for new_round.
REQ-004 SHALL have parameter HOLD_STEPS, default 3, number of stepped cycles results are held before an auto restart (>=1).
REQ-005 SHALL have port slow_clock, input, 1, the sole clock; all state updates on its rising edge.
REQ-006 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port step, input, 1, advance enable; when 0, the FSM and counters hold.
REQ-008 SHALL have port new_round, input, 1, request for the next round, sampled in S_DONE when AUTO_NEXT=0.
REQ-009 SHALL have port pscore, input, 4, player hand score 0-9 from the card datapath.
REQ-010 SHALL have port dscore, input, 4, dealer hand score 0-9.
REQ-011 SHALL have port pcard3, input, 4, value of the player third card 0-9.
REQ-012 SHALL have port load_pcard, output, 3, one-hot load strobe for player card slot 1..3 (bit0 = card1).
REQ-013 SHALL have port load_dcard, output, 3, one-hot load strobe for dealer card slot 1..3.
REQ-014 SHALL have port clear_hands, output, 1, datapath hand clear between rounds.
REQ-015 SHALL have port player_win_light, output, 1, player won the last round (both lights = tie).
REQ-016 SHALL have port dealer_win_light, output, 1, dealer won the last round.
REQ-017 SHALL have ports player_wins, dealer_wins and ties, output, TALLY_W each, round-result counters.
REQ-018 SHALL have port match_over, output, 1, a win counter reached TARGET_WINS.

Function
REQ-019 SHALL use states S_PC1, S_DC1, S_PC2, S_DC2, S_EVAL, S_PC3, S_BDEC, S_DC3, S_RESULT, S_DONE and S_CLEAR, with all transitions taken only on a slow_clock edge with step=1.
REQ-020 SHALL drive the load strobes Moore-style: load_pcard[0] in S_PC1, load_dcard[0] in S_DC1, load_pcard[1] in S_PC2, load_dcard[1] in S_DC2, load_pcard[2] in S_PC3, load_dcard[2] in S_DC3, and all zero elsewhere; the datapath captures a card on the edge that leaves the state, so the updated score is valid in the next state.
REQ-021 SHALL sequence S_PC1->S_DC1->S_PC2->S_DC2->S_EVAL.
REQ-022 SHALL, in S_EVAL, go to S_RESULT on a natural (pscore>=8 or dscore>=8); otherwise go to S_PC3 if pscore<=5, else to S_DC3 if dscore<=5, else to S_RESULT.
REQ-023 SHALL go S_PC3->S_BDEC.
REQ-024 SHALL, in S_BDEC with v=pcard3, draw (go to S_DC3) when dscore<=2; when dscore=3 and v!=8; when dscore=4 and v in 2..7; when dscore=5 and v in 4..7; when dscore=6 and v in 6..7; otherwise go to S_RESULT.
REQ-025 SHALL go S_DC3->S_RESULT.
REQ-026 SHALL, in S_RESULT, compare pscore and dscore, register the lights (player>dealer: player light only; dealer>player: dealer light only; equal: both), increment exactly one counter, and go to S_DONE.
REQ-027 SHALL saturate every counter at 2^TALLY_W-1.
REQ-028 SHALL assert match_over registered, set together with the counter update that makes player_wins or dealer_wins equal TARGET_WINS; ties never end the match.
REQ-029 SHALL hold the lights in S_DONE; with match_over=1, S_DONE is terminal until reset, and new_round and step are ignored.
REQ-030 SHALL, in S_DONE with AUTO_NEXT=0, go to S_CLEAR on step=1 with new_round=1.
REQ-031 SHALL, in S_DONE with AUTO_NEXT=1, count HOLD_STEPS stepped cycles and then go to S_CLEAR; new_round is ignored.
REQ-032 SHALL assert clear_hands only in S_CLEAR, clear both lights on leaving S_CLEAR, and go S_CLEAR->S_PC1; counters are preserved.

Reset
REQ-033 SHALL, on resetb=0 at any time including mid-round, immediately set the state to S_PC1, all counters 0, both lights 0, match_over 0 and the hold counter 0; load_pcard[0] is then 1, and all other outputs are 0.

Structure
REQ-034 SHALL place the state enum, the natural threshold (8), the player stand threshold (5) and the banker draw table in package baccarat_pkg.
REQ-035 SHALL implement the S_BDEC decision as combinational sub-module banker_draw_rule (inputs dscore and pcard3, output draw).

Verification
REQ-036 SHALL include a natural test: pscore 2->7, dscore 4->8 -> S_EVAL to S_RESULT, dealer_win_light=1, dealer_wins=1.
REQ-037 SHALL include a player-draw test: two-card scores p=3, d=3, then pcard3=8 -> no dealer draw; with final p=1, d=3, dealer_wins increments.
REQ-038 SHALL include a banker-draw test: p=4, d=6, pcard3=6 -> load_dcard[2] pulses; final p=0, d=9 -> dealer light.
REQ-039 SHALL include a tie and hold test: final p=6, d=6 -> both lights and ties=1; with step=0 for 5 edges the state and lights hold.
REQ-040 SHALL include a match-end test with TARGET_WINS=2 and AUTO_NEXT=1: two player wins -> match_over=1 and no S_CLEAR; new_round is ignored.
REQ-041 SHALL include a reset-in-S_DC3 test -> immediate S_PC1, all counters 0 and lights 0 without a clock edge.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat match controller.
//   state_t           - controller states, one per card slot or decision point
//   NATURAL_MIN       - two-card score that ends the deal immediately
//   PLAYER_STAND_MIN  - scores above this stand; at or below this they draw
//   BANKER_DRAW_TABLE - per dealer score 0..7, bit v set when the dealer draws
//                       against a player third card of value v
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_PC1,
    S_DC1,
    S_PC2,
    S_DC2,
    S_EVAL,
    S_PC3,
    S_BDEC,
    S_DC3,
    S_RESULT,
    S_DONE,
    S_CLEAR
  } state_t;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd5;

  // Element [d] is indexed by the player third card value (bits 0..9).
  localparam logic [7:0][9:0] BANKER_DRAW_TABLE = {
    10'h000,  // d = 7: always stand
    10'h0C0,  // d = 6: v in 6..7
    10'h0F0,  // d = 5: v in 4..7
    10'h0FC,  // d = 4: v in 2..7
    10'h2FF,  // d = 3: any v except 8
    10'h3FF,  // d = 2: always draw
    10'h3FF,  // d = 1
    10'h3FF   // d = 0
  };

endpackage

// File: rtl/banker_draw_rule.sv
// Dealer third-card decision, used once the player has taken a third card.
//   dscore - dealer two-card score 0..9
//   pcard3 - value of the player third card 0..9
//   draw   - 1 when the dealer must take a third card
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    if (dscore <= 4'd7 && pcard3 <= 4'd9) begin
      draw = BANKER_DRAW_TABLE[dscore[2:0]][pcard3];
    end
    // Low dealer scores draw regardless of the card value.
    if (dscore <= 4'd2) begin
      draw = 1'b1;
    end
  end

endmodule

// File: rtl/baccarat_match_ctrl.sv
// Round sequencer and match bookkeeping for a baccarat table.
//   slow_clock, resetb      - clock and asynchronous active-low reset
//   step                    - advance enable; all state holds while low
//   new_round               - manual request for the next round (AUTO_NEXT = 0)
//   pscore, dscore, pcard3  - hand scores and player third card from the datapath
//   load_pcard, load_dcard  - one-hot card slot load strobes (bit0 = card 1)
//   clear_hands             - datapath hand clear between rounds
//   player/dealer_win_light - last round result, both lit on a tie
//   player_wins, dealer_wins, ties - saturating round-result counters
//   match_over              - a win counter reached TARGET_WINS; holds until reset
module baccarat_match_ctrl
  import baccarat_pkg::*;
#(
  parameter int unsigned TALLY_W     = 4,
  parameter int unsigned TARGET_WINS = 3,
  parameter int unsigned AUTO_NEXT   = 0,
  parameter int unsigned HOLD_STEPS  = 3
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               step,
  input  logic               new_round,
  input  logic [3:0]         pscore,
  input  logic [3:0]         dscore,
  input  logic [3:0]         pcard3,
  output logic [2:0]         load_pcard,
  output logic [2:0]         load_dcard,
  output logic               clear_hands,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties,
  output logic               match_over
);

  localparam int unsigned HoldW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HoldW-1:0]   HoldLast = HoldW'(HOLD_STEPS - 1);
  localparam logic [TALLY_W-1:0] TallyMax = '1;
  localparam logic [TALLY_W-1:0] Target   = TALLY_W'(TARGET_WINS);
  localparam logic [TALLY_W-1:0] TallyOne = TALLY_W'(1);

  state_t             state_q, state_d;
  logic               pl_q, pl_d, dl_q, dl_d;
  logic [TALLY_W-1:0] pw_q, pw_d, dw_q, dw_d, ti_q, ti_d;
  logic               mo_q, mo_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               bank_draw;

  banker_draw_rule u_banker_draw_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (bank_draw)
  );

  always_comb begin
    state_d     = state_q;
    pl_d        = pl_q;
    dl_d        = dl_q;
    pw_d        = pw_q;
    dw_d        = dw_q;
    ti_d        = ti_q;
    mo_d        = mo_q;
    hold_d      = hold_q;
    load_pcard  = 3'b000;
    load_dcard  = 3'b000;
    clear_hands = 1'b0;

    unique case (state_q)
      S_PC1:   load_pcard = 3'b001;
      S_DC1:   load_dcard = 3'b001;
      S_PC2:   load_pcard = 3'b010;
      S_DC2:   load_dcard = 3'b010;
      S_PC3:   load_pcard = 3'b100;
      S_DC3:   load_dcard = 3'b100;
      S_CLEAR: clear_hands = 1'b1;
      default: ;
    endcase

    if (step) begin
      unique case (state_q)
        S_PC1: state_d = S_DC1;
        S_DC1: state_d = S_PC2;
        S_PC2: state_d = S_DC2;
        S_DC2: state_d = S_EVAL;
        S_EVAL: begin
          if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) begin
            state_d = S_RESULT;
          end else if (pscore <= PLAYER_STAND_MIN) begin
            state_d = S_PC3;
          end else if (dscore <= PLAYER_STAND_MIN) begin
            state_d = S_DC3;
          end else begin
            state_d = S_RESULT;
          end
        end
        S_PC3:  state_d = S_BDEC;
        S_BDEC: state_d = bank_draw ? S_DC3 : S_RESULT;
        S_DC3:  state_d = S_RESULT;
        S_RESULT: begin
          if (pscore > dscore) begin
            pl_d = 1'b1;
            dl_d = 1'b0;
            if (pw_q != TallyMax) pw_d = pw_q + TallyOne;
          end else if (dscore > pscore) begin
            pl_d = 1'b0;
            dl_d = 1'b1;
            if (dw_q != TallyMax) dw_d = dw_q + TallyOne;
          end else begin
            pl_d = 1'b1;
            dl_d = 1'b1;
            if (ti_q != TallyMax) ti_d = ti_q + TallyOne;
          end
          // Ties cannot end the match; only the win counters are compared.
          mo_d    = mo_q | (pw_d == Target) | (dw_d == Target);
          state_d = S_DONE;
        end
        S_DONE: begin
          // A finished match parks here until reset.
          if (!mo_q) begin
            if (AUTO_NEXT != 0) begin
              if (hold_q == HoldLast) begin
                hold_d  = '0;
                state_d = S_CLEAR;
              end else begin
                hold_d = hold_q + 1'b1;
              end
            end else if (new_round) begin
              state_d = S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          pl_d    = 1'b0;
          dl_d    = 1'b0;
          state_d = S_PC1;
        end
        default: state_d = S_PC1;
      endcase
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_PC1;
      pl_q    <= 1'b0;
      dl_q    <= 1'b0;
      pw_q    <= '0;
      dw_q    <= '0;
      ti_q    <= '0;
      mo_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
      dl_q    <= dl_d;
      pw_q    <= pw_d;
      dw_q    <= dw_d;
      ti_q    <= ti_d;
      mo_q    <= mo_d;
      hold_q  <= hold_d;
    end
  end

  assign player_win_light = pl_q;
  assign dealer_win_light = dl_q;
  assign player_wins      = pw_q;
  assign dealer_wins      = dw_q;
  assign ties             = ti_q;
  assign match_over       = mo_q;

endmodule

// File: tb/tb_baccarat_match_ctrl.sv
// Scoreboard bench: dut1 runs the defaults (manual rounds, target 3); dut2 runs
// target 2 with automatic restart. Only one is out of reset at a time.
module tb_baccarat_match_ctrl;
  import baccarat_pkg::*;

  logic slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  logic       resetb1, resetb2, step, new_round;
  logic [3:0] pscore, dscore, pcard3;

  logic [2:0] lp1, ld1, lp2, ld2;
  logic       ch1, pl1, dl1, mo1, ch2, pl2, dl2, mo2;
  logic [3:0] pw1, dw1, ti1, pw2, dw2, ti2;

  baccarat_match_ctrl dut1 (
    .slow_clock(slow_clock), .resetb(resetb1), .step(step), .new_round(new_round),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard(lp1), .load_dcard(ld1), .clear_hands(ch1),
    .player_win_light(pl1), .dealer_win_light(dl1),
    .player_wins(pw1), .dealer_wins(dw1), .ties(ti1), .match_over(mo1)
  );

  baccarat_match_ctrl #(
    .TALLY_W(4), .TARGET_WINS(2), .AUTO_NEXT(1), .HOLD_STEPS(3)
  ) dut2 (
    .slow_clock(slow_clock), .resetb(resetb2), .step(step), .new_round(new_round),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard(lp2), .load_dcard(ld2), .clear_hands(ch2),
    .player_win_light(pl2), .dealer_win_light(dl2),
    .player_wins(pw2), .dealer_wins(dw2), .ties(ti2), .match_over(mo2)
  );

  // Observed view of the DUT under test.
  logic       sel;
  state_t     st;
  logic [2:0] lp, ld;
  logic       ch, pl, dl, mo;
  logic [3:0] pw, dw, ti;
  assign st = sel ? dut2.state_q : dut1.state_q;
  assign lp = sel ? lp2 : lp1;
  assign ld = sel ? ld2 : ld1;
  assign ch = sel ? ch2 : ch1;
  assign pl = sel ? pl2 : pl1;
  assign dl = sel ? dl2 : dl1;
  assign mo = sel ? mo2 : mo1;
  assign pw = sel ? pw2 : pw1;
  assign dw = sel ? dw2 : dw1;
  assign ti = sel ? ti2 : ti1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard of round results.
  typedef struct packed {
    logic       pl;
    logic       dl;
    logic [3:0] pw;
    logic [3:0] dw;
    logic [3:0] ti;
    logic       mo;
  } res_t;

  res_t exp_q[$];
  int   m_pw, m_dw, m_ti, m_target;
  logic m_mo;

  function automatic void model_reset(input int target);
    m_pw = 0; m_dw = 0; m_ti = 0; m_mo = 1'b0; m_target = target;
  endfunction

  function automatic void model_round(input int pf, input int df);
    res_t e;
    e.pl = (pf >= df);
    e.dl = (df >= pf);
    if (pf > df)      m_pw = (m_pw < 15) ? m_pw + 1 : 15;
    else if (df > pf) m_dw = (m_dw < 15) ? m_dw + 1 : 15;
    else              m_ti = (m_ti < 15) ? m_ti + 1 : 15;
    if (m_pw == m_target || m_dw == m_target) m_mo = 1'b1;
    e.pw = 4'(m_pw);
    e.dw = 4'(m_dw);
    e.ti = 4'(m_ti);
    e.mo = m_mo;
    exp_q.push_back(e);
  endfunction

  state_t prev_st = S_PC1;
  always @(negedge slow_clock) begin
    if (st == S_DONE && prev_st != S_DONE) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_pending", exp_q.size(), 1);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check_eq("player_light", pl, e.pl);
        check_eq("dealer_light", dl, e.dl);
        check_eq("player_wins", pw, e.pw);
        check_eq("dealer_wins", dw, e.dw);
        check_eq("ties", ti, e.ti);
        check_eq("match_over", mo, e.mo);
      end
    end
    prev_st <= st;
  end

  // Card datapath model: a strobed slot loads its score on the leaving edge.
  int pv[3];
  int dv[3];
  int lp3_cnt, ld3_cnt;

  task automatic tick();
    logic [2:0] a, b;
    logic       c, s;
    a = lp; b = ld; c = ch; s = step;
    @(negedge slow_clock);
    if (s) begin
      for (int k = 0; k < 3; k++) begin
        if (a[k]) pscore = 4'(pv[k]);
        if (b[k]) dscore = 4'(dv[k]);
      end
      if (a[2]) lp3_cnt++;
      if (b[2]) ld3_cnt++;
      if (c) begin
        pscore = 4'd0;
        dscore = 4'd0;
      end
    end
  endtask

  task automatic setup_round(input int p1, input int p2, input int p3,
                             input int d1, input int d2, input int d3, input int v);
    pv = '{p1, p2, p3};
    dv = '{d1, d2, d3};
    pcard3 = 4'(v);
    lp3_cnt = 0;
    ld3_cnt = 0;
  endtask

  // Third slots hold the final score (equal to the two-card score if unused).
  task automatic play_round(input int p1, input int p2, input int p3,
                            input int d1, input int d2, input int d3, input int v);
    int n;
    setup_round(p1, p2, p3, d1, d2, d3, v);
    model_round(p3, d3);
    n = 0;
    while (st != S_DONE && n < 20) begin
      tick();
      n++;
    end
    check_eq("round_done", st, S_DONE);
  endtask

  task automatic next_round(input bit auto_mode);
    int n;
    n = 0;
    if (auto_mode) begin
      while (st == S_DONE && n < 10) begin
        tick();
        n++;
      end
      check_eq("hold_steps", n, 3);
    end else begin
      new_round = 1'b1;
      tick();
      new_round = 1'b0;
    end
    check_eq("clear_state", st, S_CLEAR);
    check_eq("clear_hands", ch, 1);
    tick();
    check_eq("lights_cleared", {pl, dl}, 0);
    check_eq("back_to_pc1", lp, 3'b001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    int n;
    sel = 1'b0; resetb1 = 1'b0; resetb2 = 1'b0;
    step = 1'b1; new_round = 1'b0;
    pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
    model_reset(3);
    repeat (2) @(negedge slow_clock);

    // Reset state
    check_eq("rst_load_pcard", lp, 3'b001);
    check_eq("rst_load_dcard", ld, 3'b000);
    check_eq("rst_clear", ch, 0);
    check_eq("rst_lights", {pl, dl}, 0);
    check_eq("rst_counts", {pw, dw, ti}, 0);
    check_eq("rst_match_over", mo, 0);
    resetb1 = 1'b1;

    // Natural: dealer 8 stops the deal
    play_round(2, 7, 7, 4, 8, 8, 0);
    check_eq("natural_no_third", lp3_cnt + ld3_cnt, 0);
    next_round(1'b0);

    // Player draws 8 on 3; dealer on 3 stands
    play_round(3, 3, 1, 3, 3, 3, 8);
    check_eq("p3_drawn", lp3_cnt, 1);
    check_eq("d3_not_drawn", ld3_cnt, 0);
    next_round(1'b0);

    // Tie, then hold with step low
    play_round(6, 6, 6, 6, 6, 6, 0);
    step = 1'b0;
    new_round = 1'b1;
    repeat (5) tick();
    check_eq("hold_state", st, S_DONE);
    check_eq("hold_lights", {pl, dl}, 2'b11);
    check_eq("hold_ties", ti, 1);
    step = 1'b1;
    new_round = 1'b0;
    next_round(1'b0);

    // Player natural 9
    play_round(9, 9, 9, 0, 0, 0, 0);
    next_round(1'b0);

    // Reset while in S_DC3
    setup_round(4, 4, 0, 6, 6, 9, 6);
    n = 0;
    while (ld != 3'b100 && n < 20) begin
      tick();
      n++;
    end
    check_eq("reach_dc3", st, S_DC3);
    #2 resetb1 = 1'b0;
    #1;
    check_eq("mid_rst_state", st, S_PC1);
    check_eq("mid_rst_load_pcard", lp, 3'b001);
    check_eq("mid_rst_load_dcard", ld, 3'b000);
    check_eq("mid_rst_counts", {pw, dw, ti}, 0);
    check_eq("mid_rst_lights", {pl, dl}, 0);
    pscore = 4'd0;
    dscore = 4'd0;
    model_reset(3);
    @(negedge slow_clock);
    resetb1 = 1'b1;

    // Banker draws: d=6 against third card 6
    play_round(4, 4, 0, 6, 6, 9, 6);
    check_eq("bank_d3_pulse", ld3_cnt, 1);
    next_round(1'b0);

    // dut2: auto restart, tie saturation, match end at 2 player wins
    resetb1 = 1'b0;
    sel = 1'b1;
    pscore = 4'd0;
    dscore = 4'd0;
    model_reset(2);
    @(negedge slow_clock);
    resetb2 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      play_round(6, 6, 6, 6, 6, 6, 0);
      next_round(1'b1);
    end
    check_eq("ties_saturated", ti, 15);
    play_round(9, 9, 9, 0, 0, 0, 0);
    next_round(1'b1);
    play_round(8, 8, 8, 1, 1, 1, 0);
    new_round = 1'b1;
    n = 0;
    repeat (8) begin
      tick();
      if (ch) n++;
    end
    new_round = 1'b0;
    check_eq("terminal_state", st, S_DONE);
    check_eq("terminal_no_clear", n, 0);
    check_eq("terminal_match_over", mo, 1);
    check_eq("terminal_player_wins", pw, 2);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
